alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Round-robin arbiter that shares the single 16-bit ALU among NUM_CORES requesting cores. It grants one core at a time and drives that core's operands and opcode into the ALU. It waits out the ALU's registered result and zero-flag latency, then returns the result and zero flag with a one-cycle done pulse. Illegal opcodes and divide/modulo-by-zero are rejected without using the ALU.

Parameters:
NUM_CORES, 4, number of requesting cores (2..8)
DATA_W, 16, operand/result width; must match ALU
OP_W, 3, opcode width; must match ALU

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_req  input  NUM_CORES  per-core request level
i_op  input  NUM_CORES*OP_W  per-core opcode, core k at bits [k*OP_W +: OP_W]
i_in1  input  NUM_CORES*DATA_W  per-core operand 1, same packing
i_in2  input  NUM_CORES*DATA_W  per-core operand 2, same packing
o_grant  output  NUM_CORES  one-hot owner of ALU, ISSUE..ZF states
o_done  output  NUM_CORES  one-hot one-cycle completion pulse
o_result  output  DATA_W  broadcast result, valid while o_done nonzero
o_zero  output  1  broadcast zero flag, valid while o_done nonzero
o_err  output  1  rejected request, valid while o_done nonzero
o_busy  output  1  high in every state except IDLE
o_alu_op  output  OP_W  to ALU opcode
o_alu_in1  output  DATA_W  to ALU operand 1
o_alu_in2  output  DATA_W  to ALU operand 2
i_alu_out  input  DATA_W  ALU result; registered, valid 1 cycle after inputs
i_alu_z  input  1  ALU zero flag; registered from i_alu_out, valid 1 cycle after i_alu_out

Behaviour:
- Reset: all outputs 0 (o_alu_op=0 is ALU no-op, ALU holds state); state IDLE; rr pointer = NUM_CORES-1, so core 0 has top priority.
- Legal ops: 1 add, 2 sub, 3 mul, 4 div, 5 mod. Ops 0, 6, 7 are illegal. Op 4 or 5 with in1==0 is illegal.
- States: IDLE, ISSUE, RES, ZF, DONE. All outputs are registered.
- IDLE (cycle T): if any i_req, pick the first requester strictly after the pointer, wrapping. Pointer <= winner. Latch that core's op/in1/in2.
  - Legal: next ISSUE. Drive o_alu_op/in1/in2 and o_grant from T+1.
  - Illegal: next DONE. o_alu_op stays 0, no grant.
- ISSUE (T+1) -> RES (T+2) -> ZF (T+3): ALU inputs and o_grant held constant.
- At end of ZF: capture i_alu_out into o_result and i_alu_z into o_zero. o_alu_op<=0, o_grant<=0. Go to DONE.
- DONE (T+4 legal, T+1 illegal): o_done[winner]=1 for exactly this cycle.
  - Legal: o_result/o_zero as captured, o_err=0.
  - Illegal: o_result=0, o_zero=1, o_err=1.
  - Next state always IDLE. No arbitration in DONE.
- Request latency: legal request sampled at T completes at T+4. Minimum grant spacing is 5 cycles.
- Requester protocol: hold i_req and operands stable until its o_done. Deassert i_req by the cycle after o_done.
  - If a requester keeps i_req high, it is re-arbitrated with lowest priority.
  - Dropping i_req after grant is ignored; the op completes and o_done still pulses.
- Operand changes after the IDLE sample are ignored.
- Width rules: no truncation or extension here. Result semantics, including mul truncation to DATA_W and sub saturating to 0, belong to the ALU and are passed through unmodified.
- i_rst in any state: next cycle is reset state. No o_done for the aborted op, and o_alu_op is 0 in that cycle.
- i_rst has priority over arbitration in the same cycle.

Test Plan:
- Reset, then core0 requests op=1, in1=5, in2=7 -> o_grant=0001 for 3 cycles, o_alu_op=1; o_done=0001 4 cycles after sample; o_result=12, o_zero=0, o_err=0.
- All four cores request op=1 at the same time right after reset -> completion order 0,1,2,3; o_done pulses 5 cycles apart; o_grant stays one-hot throughout.
- Core2 requests op=2, in1=9, in2=3 -> o_result=0, o_zero=1, o_err=0.
- Core1 requests op=4, in1=0 -> o_done=0010 one cycle after sample; o_err=1, o_result=0, o_zero=1; o_alu_op never leaves 0.
- Core3 holds i_req high continuously and core0 requests while core3 is in RES -> core0 wins the next grant; core3 is re-granted afterwards.
- i_rst pulsed while in RES state -> next cycle o_grant=0, o_alu_op=0, o_busy=0; no o_done; a following core1 request completes normally.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Round-robin arbiter sharing one registered 16-bit ALU among NUM_CORES
//   cores. One request is accepted at a time. Its operands are driven into
//   the ALU, the ALU's registered result and zero-flag latency is waited out,
//   and the outcome is returned with a one-cycle one-hot done pulse. Illegal
//   opcodes and div/mod by zero are rejected without touching the ALU.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_req                per-core request level
//   i_op/i_in1/i_in2     per-core opcode and operands, core k at [k*W +: W]
//   o_grant              one-hot ALU owner (ISSUE, RES and ZF states)
//   o_done               one-hot one-cycle completion pulse
//   o_result/o_zero/o_err  broadcast outcome, valid while o_done != 0
//   o_busy               high in every state except IDLE
//   o_alu_op/in1/in2     to ALU (op 0 is the ALU no-op)
//   i_alu_out, i_alu_z   from ALU; result valid 1 cycle after inputs,
//                        zero flag 1 cycle after the result
//
// Handshake: a core raises i_req with stable operands and holds them until
// its o_done pulse. The request is sampled only in IDLE; later operand
// changes, or dropping i_req after acceptance, do not affect the operation.
// A core that keeps i_req high after o_done is treated as a new request and
// competes with the lowest priority, because the pointer now names it.
module alu_share_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16,
  parameter int OP_W      = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_CORES-1:0]        i_req,
  input  logic [NUM_CORES*OP_W-1:0]   i_op,
  input  logic [NUM_CORES*DATA_W-1:0] i_in1,
  input  logic [NUM_CORES*DATA_W-1:0] i_in2,
  output logic [NUM_CORES-1:0]        o_grant,
  output logic [NUM_CORES-1:0]        o_done,
  output logic [DATA_W-1:0]           o_result,
  output logic                        o_zero,
  output logic                        o_err,
  output logic                        o_busy,
  output logic [OP_W-1:0]             o_alu_op,
  output logic [DATA_W-1:0]           o_alu_in1,
  output logic [DATA_W-1:0]           o_alu_in2,
  input  logic [DATA_W-1:0]           i_alu_out,
  input  logic                        i_alu_z
);

  localparam int PTR_W = $clog2(NUM_CORES);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MOD = OP_W'(5);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RES, S_ZF, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PTR_W-1:0]      r_ptr;        // last winner; also owner of the op in flight
  logic [NUM_CORES-1:0]  r_grant;
  logic [NUM_CORES-1:0]  r_done;
  logic [DATA_W-1:0]     r_result;
  logic                  r_zero;
  logic                  r_err;
  logic                  r_busy;
  logic [OP_W-1:0]       r_alu_op;
  logic [DATA_W-1:0]     r_alu_in1;
  logic [DATA_W-1:0]     r_alu_in2;

  logic                  w_found;
  logic [PTR_W-1:0]      w_win;
  logic [OP_W-1:0]       w_op;
  logic [DATA_W-1:0]     w_in1;
  logic [DATA_W-1:0]     w_in2;
  logic                  w_legal;
  int                    w_dist;
  int                    w_best;

  logic [PTR_W-1:0]      w_ptr_nxt;
  logic [NUM_CORES-1:0]  w_grant_nxt;
  logic [NUM_CORES-1:0]  w_done_nxt;
  logic [DATA_W-1:0]     w_result_nxt;
  logic                  w_zero_nxt;
  logic                  w_err_nxt;
  logic [OP_W-1:0]       w_alu_op_nxt;
  logic [DATA_W-1:0]     w_alu_in1_nxt;
  logic [DATA_W-1:0]     w_alu_in2_nxt;

  // Round-robin pick: each requester's distance is counted from the slot
  // just after the pointer, so the previous winner is considered last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_op    = '0;
    w_in1   = '0;
    w_in2   = '0;
    w_best  = NUM_CORES;
    w_dist  = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_dist = k - int'(r_ptr) - 1;
      if (w_dist < 0) w_dist = w_dist + NUM_CORES;
      if (i_req[k] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_found = 1'b1;
        w_win   = PTR_W'(k);
        w_op    = i_op[k*OP_W +: OP_W];
        w_in1   = i_in1[k*DATA_W +: DATA_W];
        w_in2   = i_in2[k*DATA_W +: DATA_W];
      end
    end
  end

  // in1 is the divisor for div/mod, so in1 == 0 is the divide-by-zero case.
  assign w_legal = (w_op >= OP_ADD) && (w_op <= OP_MOD) &&
                   !(((w_op == OP_DIV) || (w_op == OP_MOD)) && (w_in1 == '0));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = w_legal ? S_ISSUE : S_DONE;
      S_ISSUE: w_state_nxt = S_RES;
      S_RES:   w_state_nxt = S_ZF;
      S_ZF:    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. ALU drive and grant
  // hold by default; the outcome fields exist only for the DONE cycle.
  always_comb begin
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    w_alu_op_nxt  = r_alu_op;
    w_alu_in1_nxt = r_alu_in1;
    w_alu_in2_nxt = r_alu_in2;
    w_done_nxt    = '0;
    w_result_nxt  = '0;
    w_zero_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_ptr_nxt = w_win;
          if (w_legal) begin
            w_grant_nxt   = NUM_CORES'(1) << w_win;
            w_alu_op_nxt  = w_op;
            w_alu_in1_nxt = w_in1;
            w_alu_in2_nxt = w_in2;
          end else begin
            w_done_nxt = NUM_CORES'(1) << w_win;
            w_zero_nxt = 1'b1;
            w_err_nxt  = 1'b1;
          end
        end
      end
      S_ZF: begin
        // Result has been stable since RES, zero flag arrives one cycle later.
        w_done_nxt    = NUM_CORES'(1) << r_ptr;
        w_result_nxt  = i_alu_out;
        w_zero_nxt    = i_alu_z;
        w_grant_nxt   = '0;
        w_alu_op_nxt  = '0;
        w_alu_in1_nxt = '0;
        w_alu_in2_nxt = '0;
      end
      default: ;
    endcase
  end

  // Output and pointer registers. Reset points at the last core so core 0
  // has top priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr     <= PTR_W'(NUM_CORES - 1);
      r_grant   <= '0;
      r_done    <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_alu_op  <= '0;
      r_alu_in1 <= '0;
      r_alu_in2 <= '0;
    end else begin
      r_ptr     <= w_ptr_nxt;
      r_grant   <= w_grant_nxt;
      r_done    <= w_done_nxt;
      r_result  <= w_result_nxt;
      r_zero    <= w_zero_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_alu_op  <= w_alu_op_nxt;
      r_alu_in1 <= w_alu_in1_nxt;
      r_alu_in2 <= w_alu_in2_nxt;
    end
  end

  assign o_grant   = r_grant;
  assign o_done    = r_done;
  assign o_result  = r_result;
  assign o_zero    = r_zero;
  assign o_err     = r_err;
  assign o_busy    = r_busy;
  assign o_alu_op  = r_alu_op;
  assign o_alu_in1 = r_alu_in1;
  assign o_alu_in2 = r_alu_in2;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Bench for alu_share_arbiter with a registered ALU model attached. A
//   transaction-level reference model predicts, for every clock edge, which
//   core owns the ALU, when done pulses and what the outcome must be, from
//   the sample edge and fixed offsets. Directed scenarios pin the model with
//   literal expectations, then randomized requesters exercise it.
module tb_alu_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int OW = 3;
  localparam int EW = 3 + DW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0;
  logic [N*OW-1:0] op  = '0;
  logic [N*DW-1:0] in1 = '0;
  logic [N*DW-1:0] in2 = '0;
  logic [N-1:0]    o_grant, o_done;
  logic [DW-1:0]   o_result, o_alu_in1, o_alu_in2;
  logic            o_zero, o_err, o_busy;
  logic [OW-1:0]   o_alu_op;
  logic [DW-1:0]   alu_out = '0;
  logic            alu_z   = 1'b1;

  alu_share_arbiter #(.NUM_CORES(N), .DATA_W(DW), .OP_W(OW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_op(op), .i_in1(in1), .i_in2(in2),
    .o_grant(o_grant), .o_done(o_done), .o_result(o_result), .o_zero(o_zero),
    .o_err(o_err), .o_busy(o_busy), .o_alu_op(o_alu_op),
    .o_alu_in1(o_alu_in1), .o_alu_in2(o_alu_in2),
    .i_alu_out(alu_out), .i_alu_z(alu_z)
  );

  // ALU function: sub saturates at 0, in1 is the divisor, op 0/6/7 hold.
  function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] f_op,
                                          input logic [DW-1:0] a, b, hold);
    logic [DW-1:0] r;
    case (f_op)
      3'd1: r = a + b;
      3'd2: r = (b >= a) ? b - a : '0;
      3'd3: r = a * b;
      3'd4: r = b / a;
      3'd5: r = b % a;
      default: r = hold;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    alu_out <= alu_f(o_alu_op, o_alu_in1, o_alu_in2, alu_out);
    alu_z   <= (alu_out == '0);
  end

  // ---------------- checking helpers ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int              cyc = 0;
  bit              m_have = 1'b0;
  int              m_s, m_win, m_d;
  int              m_ptr = N - 1;
  bit              m_legal, m_free, m_found;
  logic [OW-1:0]   m_op;
  logic [DW-1:0]   m_in1, m_in2, m_res;
  logic            m_zero;
  logic [EW-1:0]   exp_q[$];
  logic [N-1:0]    e_grant = '0, e_done = '0;
  logic            e_busy = 1'b0;
  logic [OW-1:0]   e_op = '0;

  // Expected outputs after each edge follow from the offset d of this edge
  // from the accepting edge: legal ops own the ALU for d=0..2 and complete
  // at d=3; rejected ops complete at d=0. A new request is accepted only
  // once the previous one has fully drained back to IDLE.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_have = 1'b0;
      m_ptr  = N - 1;
      exp_q.delete();
    end else begin
      m_free = !m_have || ((cyc - m_s) >= (m_legal ? 5 : 2));
      if (m_free && (req != '0)) begin
        m_found = 1'b0;
        for (int i = 1; i <= N; i++) begin
          if (!m_found && req[(m_ptr + i) % N]) begin
            m_found = 1'b1;
            m_win   = (m_ptr + i) % N;
          end
        end
        m_ptr   = m_win;
        m_s     = cyc;
        m_have  = 1'b1;
        m_op    = op[m_win*OW +: OW];
        m_in1   = in1[m_win*DW +: DW];
        m_in2   = in2[m_win*DW +: DW];
        m_legal = (m_op >= 1) && (m_op <= 5) && !((m_op >= 4) && (m_in1 == 0));
        m_res   = m_legal ? alu_f(m_op, m_in1, m_in2, '0) : '0;
        m_zero  = m_legal ? (m_res == 0) : 1'b1;
        exp_q.push_back({3'(m_win), m_res, m_zero, !m_legal});
      end
    end
    e_grant = '0; e_done = '0; e_busy = 1'b0; e_op = '0;
    if (!rst && m_have) begin
      m_d = cyc - m_s;
      if (m_legal) begin
        if (m_d <= 2) begin
          e_grant = N'(1) << m_win;
          e_op    = m_op;
        end
        if (m_d == 3) e_done = N'(1) << m_win;
        e_busy = (m_d <= 3);
      end else begin
        if (m_d == 0) e_done = N'(1) << m_win;
        e_busy = (m_d == 0);
      end
    end
  end

  // ---------------- compare process and monitor ----------------
  int   done_core[$], done_cyc[$];
  logic [DW-1:0] done_res[$];
  logic done_z[$], done_err[$];
  int   grant_cnt[N];
  int   alu_nz_cnt = 0;
  int   d_core;
  logic [EW-1:0] ex;

  always @(negedge clk) begin
    check("grant", o_grant, e_grant);
    check("grant_onehot", $onehot0(o_grant), 1);
    check("done", o_done, e_done);
    check("busy", o_busy, e_busy);
    check("alu_op", o_alu_op, e_op);
    if (e_grant != '0) begin
      check("alu_in1", o_alu_in1, m_in1);
      check("alu_in2", o_alu_in2, m_in2);
    end
    for (int k = 0; k < N; k++) if (o_grant[k]) grant_cnt[k]++;
    if (o_alu_op != '0) alu_nz_cnt++;
    if (o_done != '0) begin
      d_core = 0;
      for (int k = 0; k < N; k++) if (o_done[k]) d_core = k;
      done_core.push_back(d_core);
      done_cyc.push_back(cyc);
      done_res.push_back(o_result);
      done_z.push_back(o_zero);
      done_err.push_back(o_err);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done: got done=0x%0h expected no completion", o_done);
      end else begin
        ex = exp_q.pop_front();
        check("sb_core", d_core, ex[EW-1 -: 3]);
        check("sb_result", o_result, ex[DW+1:2]);
        check("sb_zero", o_zero, ex[1]);
        check("sb_err", o_err, ex[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit keep[N];

  task automatic set_core(input int k, input logic r, input logic [OW-1:0] o,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    req[k] = r;
    op[k*OW +: OW] = o;
    in1[k*DW +: DW] = a;
    in2[k*DW +: DW] = b;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    for (int k = 0; k < N; k++) if (o_done[k] && !keep[k]) req[k] = 1'b0;
  endtask

  task automatic clear_logs();
    done_core.delete(); done_cyc.delete(); done_res.delete();
    done_z.delete(); done_err.delete();
    for (int k = 0; k < N; k++) grant_cnt[k] = 0;
    alu_nz_cnt = 0;
  endtask

  task automatic wait_dones(input int n, input int max_cycles);
    int t;
    t = 0;
    while ((done_core.size() < n) && (t < max_cycles)) begin
      step();
      t++;
    end
    check("wait_done_in_budget", (done_core.size() >= n), 1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic rand_core(input int k);
    logic [DW-1:0] a, b;
    a = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(0, 20));
    b = ($urandom_range(0, 7) == 0) ? DW'($urandom_range(0, 65535)) : DW'($urandom_range(0, 300));
    set_core(k, 1'b1, OW'($urandom_range(0, 7)), a, b);
  endtask

  task automatic rand_step();
    @(posedge clk);
    #2;
    rst = ($urandom_range(0, 299) == 0);
    for (int k = 0; k < N; k++) begin
      if (o_done[k]) begin
        if ($urandom_range(0, 1) == 1) rand_core(k);
        else req[k] = 1'b0;
      end else if (!req[k]) begin
        if ($urandom_range(0, 3) == 0) rand_core(k);
      end else if (o_grant[k] && ($urandom_range(0, 15) == 0)) begin
        req[k] = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int a;

  initial begin
    for (int k = 0; k < N; k++) keep[k] = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_grant", o_grant, 0);
    check("rst_done", o_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_alu_op", o_alu_op, 0);
    check("rst_result", o_result, 0);
    check("rst_zero", o_zero, 0);
    check("rst_err", o_err, 0);

    // core0 add 5+7
    clear_logs();
    a = cyc;
    set_core(0, 1'b1, 3'd1, 16'd5, 16'd7);
    wait_dones(1, 20);
    if (done_core.size() >= 1) begin
      check("t1_core", done_core[0], 0);
      check("t1_result", done_res[0], 12);
      check("t1_zero", done_z[0], 0);
      check("t1_err", done_err[0], 0);
      check("t1_latency", done_cyc[0] - a, 4);
    end
    check("t1_grant_cycles", grant_cnt[0], 3);
    repeat (2) step();

    // all four cores at once right after reset
    reset_pulse();
    clear_logs();
    for (int k = 0; k < N; k++) set_core(k, 1'b1, 3'd1, DW'(k*3 + 1), 16'd100);
    wait_dones(4, 40);
    if (done_core.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t2_order", done_core[i], i);
        check("t2_result", done_res[i], i*3 + 101);
      end
      for (int i = 1; i < 4; i++) check("t2_spacing", done_cyc[i] - done_cyc[i-1], 5);
    end
    repeat (2) step();

    // core2 saturating sub
    clear_logs();
    set_core(2, 1'b1, 3'd2, 16'd9, 16'd3);
    wait_dones(1, 20);
    if (done_core.size() >= 1) begin
      check("t3_core", done_core[0], 2);
      check("t3_result", done_res[0], 0);
      check("t3_zero", done_z[0], 1);
      check("t3_err", done_err[0], 0);
    end
    repeat (2) step();

    // core1 divide by zero is rejected
    clear_logs();
    a = cyc;
    set_core(1, 1'b1, 3'd4, 16'd0, 16'd55);
    wait_dones(1, 20);
    if (done_core.size() >= 1) begin
      check("t4_core", done_core[0], 1);
      check("t4_err", done_err[0], 1);
      check("t4_result", done_res[0], 0);
      check("t4_zero", done_z[0], 1);
      check("t4_latency", done_cyc[0] - a, 1);
    end
    check("t4_alu_idle", alu_nz_cnt, 0);
    repeat (2) step();

    // core3 holds its request; core0 arrives while core3 is in RES
    clear_logs();
    keep[3] = 1'b1;
    set_core(3, 1'b1, 3'd1, 16'd2, 16'd3);
    step();
    step();
    set_core(0, 1'b1, 3'd3, 16'd10, 16'd20);
    wait_dones(3, 40);
    keep[3] = 1'b0;
    req[3]  = 1'b0;
    if (done_core.size() >= 3) begin
      check("t5_first", done_core[0], 3);
      check("t5_second", done_core[1], 0);
      check("t5_second_result", done_res[1], 200);
      check("t5_third", done_core[2], 3);
    end
    repeat (3) step();

    // reset while core2 is in RES aborts it silently
    clear_logs();
    set_core(2, 1'b1, 3'd3, 16'd4, 16'd5);
    step();
    step();
    rst = 1'b1;
    req[2] = 1'b0;
    step();
    check("t6_grant", o_grant, 0);
    check("t6_alu_op", o_alu_op, 0);
    check("t6_busy", o_busy, 0);
    check("t6_done", o_done, 0);
    rst = 1'b0;
    repeat (6) step();
    check("t6_no_done", done_core.size(), 0);
    set_core(1, 1'b1, 3'd3, 16'd6, 16'd7);
    wait_dones(1, 20);
    if (done_core.size() >= 1) begin
      check("t6_core", done_core[0], 1);
      check("t6_result", done_res[0], 42);
      check("t6_err", done_err[0], 0);
    end
    repeat (2) step();

    // randomized requesters
    for (int i = 0; i < 2500; i++) rand_step();
    rst = 1'b0;
    req = '0;
    repeat (12) step();
    check("drain_exp_q", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
